// File: rtl/wr_ptr_xfer.sv
// Write-domain half of the FIFO pointer crossing: toggle-handshake send of
// wrPtr, toggle-handshake capture of rdPtr, and fill level / almost-full.
module wr_ptr_xfer #(
    parameter int N           = 16,
    parameter int depth       = 26624,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 4
) (
    input  logic         wrClk,
    input  logic         wrRst,
    input  logic [N-1:0] wrPtr,
    output logic [N-1:0] wrPtrXfer,
    output logic         wrReq,
    input  logic         wrAckAsync,
    input  logic [N-1:0] rdPtrXfer,
    input  logic         rdReqAsync,
    output logic         rdAck,
    output logic [N-1:0] rdPtrSync,
    output logic [N-1:0] fillLevel,
    output logic         almostFull
);

    localparam logic [N-1:0] DEPTH_W = N'(depth);
    localparam logic [N-1:0] AF_TH   = N'(depth - AF_MARGIN);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_ACK = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [N-1:0]           xfer_nxt;
    logic                   req_nxt;
    logic [SYNC_STAGES-1:0] ack_sff;
    logic [SYNC_STAGES-1:0] req_sff;
    logic                   ack_sync;
    logic                   req_sync;
    logic [N-1:0]           wr_idx;
    logic [N-1:0]           rd_idx;
    logic [N-1:0]           fill_nxt;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be at least 2");
        end
    endgenerate

    assign ack_sync = ack_sff[SYNC_STAGES-1];
    assign req_sync = req_sff[SYNC_STAGES-1];

    always_ff @(posedge wrClk or posedge wrRst) begin
        if (wrRst) begin
            ack_sff <= '0;
            req_sff <= '0;
        end else begin
            ack_sff <= {ack_sff[SYNC_STAGES-2:0], wrAckAsync};
            req_sff <= {req_sff[SYNC_STAGES-2:0], rdReqAsync};
        end
    end

    always_ff @(posedge wrClk or posedge wrRst) begin
        if (wrRst) begin
            state     <= S_IDLE;
            wrPtrXfer <= '0;
            wrReq     <= 1'b0;
        end else begin
            state     <= state_nxt;
            wrPtrXfer <= xfer_nxt;
            wrReq     <= req_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        xfer_nxt  = wrPtrXfer;
        req_nxt   = wrReq;
        unique case (state)
            S_IDLE: begin
                if (wrPtr != wrPtrXfer) begin
                    xfer_nxt  = wrPtr;
                    req_nxt   = ~wrReq;
                    state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (ack_sync == wrReq) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // rdPtrXfer is only looked at on the capture edge, when it is stable
    always_ff @(posedge wrClk or posedge wrRst) begin
        if (wrRst) begin
            rdPtrSync <= '0;
            rdAck     <= 1'b0;
        end else if (req_sync != rdAck) begin
            rdPtrSync <= rdPtrXfer;
            rdAck     <= req_sync;
        end
    end

    assign wr_idx = {1'b0, wrPtr[N-2:0]};
    assign rd_idx = {1'b0, rdPtrSync[N-2:0]};

    always_comb begin
        fill_nxt = wr_idx - rd_idx;
        if (wrPtr[N-1] != rdPtrSync[N-1]) begin
            fill_nxt = DEPTH_W - rd_idx + wr_idx;
        end
    end

    always_ff @(posedge wrClk or posedge wrRst) begin
        if (wrRst) begin
            fillLevel  <= '0;
            almostFull <= 1'b0;
        end else begin
            fillLevel  <= fill_nxt;
            almostFull <= (fill_nxt >= AF_TH);
        end
    end

endmodule

// File: tb/tb_wr_ptr_xfer.sv
// Directed bench for wr_ptr_xfer: send handshake, receive capture latency,
// fill level across lap wrap, full/empty, almost-full threshold and reset.
module tb_wr_ptr_xfer;

    logic        wrClk;
    logic        wrRst;
    logic [15:0] wrPtr;
    logic [15:0] wrPtrXfer;
    logic        wrReq;
    logic        wrAckAsync;
    logic [15:0] rdPtrXfer;
    logic        rdReqAsync;
    logic        rdAck;
    logic [15:0] rdPtrSync;
    logic [15:0] fillLevel;
    logic        almostFull;

    int compared;
    int mismatched;

    wr_ptr_xfer dut (
        .wrClk      (wrClk),
        .wrRst      (wrRst),
        .wrPtr      (wrPtr),
        .wrPtrXfer  (wrPtrXfer),
        .wrReq      (wrReq),
        .wrAckAsync (wrAckAsync),
        .rdPtrXfer  (rdPtrXfer),
        .rdReqAsync (rdReqAsync),
        .rdAck      (rdAck),
        .rdPtrSync  (rdPtrSync),
        .fillLevel  (fillLevel),
        .almostFull (almostFull)
    );

    initial wrClk = 1'b0;
    always #5 wrClk = ~wrClk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge wrClk);
            #1;
        end
    endtask

    initial begin
        int waited;
        compared   = 0;
        mismatched = 0;
        wrRst      = 1'b1;
        wrPtr      = '0;
        wrAckAsync = 1'b0;
        rdPtrXfer  = '0;
        rdReqAsync = 1'b0;
        step(3);
        chk("rst_xfer", 32'(wrPtrXfer), 32'h0);
        chk("rst_req", 32'(wrReq), 32'h0);
        chk("rst_fill", 32'(fillLevel), 32'h0);

        wrRst = 1'b0;
        step(3);
        chk("idle_req", 32'(wrReq), 32'h0);
        chk("idle_xfer", 32'(wrPtrXfer), 32'h0);
        chk("idle_rdack", 32'(rdAck), 32'h0);
        chk("idle_rdsync", 32'(rdPtrSync), 32'h0);
        chk("idle_af", 32'(almostFull), 32'h0);

        wrPtr = 16'd5;
        step(1);
        chk("send5_xfer", 32'(wrPtrXfer), 32'h5);
        chk("send5_req", 32'(wrReq), 32'h1);

        wrPtr = 16'd9;
        step(4);
        chk("hold_xfer", 32'(wrPtrXfer), 32'h5);
        chk("hold_req", 32'(wrReq), 32'h1);

        // ack needs two synchronizer edges before it can be seen
        wrAckAsync = 1'b1;
        step(2);
        chk("ack_sync_xfer", 32'(wrPtrXfer), 32'h5);
        waited = 0;
        while (wrPtrXfer !== 16'd9 && waited < 4) begin
            step(1);
            waited++;
        end
        chk("send9_xfer", 32'(wrPtrXfer), 32'h9);
        chk("send9_req", 32'(wrReq), 32'h0);
        chk("fill9", 32'(fillLevel), 32'h9);

        wrAckAsync = 1'b0;
        step(4);

        rdPtrXfer  = 16'h0003;
        rdReqAsync = 1'b1;
        step(2);
        chk("rx_early_ack", 32'(rdAck), 32'h0);
        chk("rx_early_ptr", 32'(rdPtrSync), 32'h0);
        step(1);
        chk("rx_ack", 32'(rdAck), 32'h1);
        chk("rx_ptr", 32'(rdPtrSync), 32'h3);
        rdPtrXfer = 16'h1234;
        step(5);
        chk("rx_stable_ptr", 32'(rdPtrSync), 32'h3);
        chk("rx_stable_ack", 32'(rdAck), 32'h1);
        chk("fill6", 32'(fillLevel), 32'h6);

        rdPtrXfer  = 16'h67FE;
        rdReqAsync = 1'b0;
        step(3);
        chk("rx_wrap_ptr", 32'(rdPtrSync), 32'h67FE);
        chk("rx_wrap_ack", 32'(rdAck), 32'h0);
        wrPtr = 16'h8002;
        step(1);
        chk("wrap_fill", 32'(fillLevel), 32'h4);
        chk("wrap_af", 32'(almostFull), 32'h0);
        chk("wait_req", 32'(wrReq), 32'h1);

        rdPtrXfer  = 16'h0100;
        rdReqAsync = 1'b1;
        wrPtr      = 16'h8100;
        step(4);
        chk("full_fill", 32'(fillLevel), 32'h6800);
        chk("full_af", 32'(almostFull), 32'h1);

        wrPtr = 16'h0100;
        step(1);
        chk("empty_fill", 32'(fillLevel), 32'h0);
        chk("empty_af", 32'(almostFull), 32'h0);

        wrPtr = 16'h80FB;
        step(1);
        chk("th_lo_fill", 32'(fillLevel), 32'h67FB);
        chk("th_lo_af", 32'(almostFull), 32'h0);
        wrPtr = 16'h80FC;
        step(1);
        chk("th_hi_fill", 32'(fillLevel), 32'h67FC);
        chk("th_hi_af", 32'(almostFull), 32'h1);
        chk("pre_rst_req", 32'(wrReq), 32'h1);

        // asynchronous reset in the middle of a clock period, mid-handshake
        #2;
        wrRst = 1'b1;
        #1;
        chk("arst_req", 32'(wrReq), 32'h0);
        chk("arst_xfer", 32'(wrPtrXfer), 32'h0);
        chk("arst_rdack", 32'(rdAck), 32'h0);
        chk("arst_rdptr", 32'(rdPtrSync), 32'h0);
        chk("arst_fill", 32'(fillLevel), 32'h0);
        chk("arst_af", 32'(almostFull), 32'h0);
        step(2);
        wrRst = 1'b0;
        step(1);
        chk("post_rst_xfer", 32'(wrPtrXfer), 32'h80FC);
        chk("post_rst_req", 32'(wrReq), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wr_ptr_xfer.md
WR_PTR_XFER -- requirements
Module: wr_ptr_xfer

Write-clock-domain half of the FIFO pointer crossing.
- Sends the write pointer to the read domain through a req/ack toggle handshake.
- Receives the read pointer from the read domain the same way; the received pointer drives the write unit's rdPtr.
- Computes fill level and almost-full.

Interface
REQ-001 Parameter N, default 16, pointer width: 1 lap bit plus N-1 index bits.
REQ-002 Parameter depth, default 16'b0110_1000_0000_0000 (26624), FIFO word count; index runs 0..depth-1.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer flop count, minimum 2.
REQ-004 Parameter AF_MARGIN, default 4, almost-full margin in words.
REQ-005 wrClk  in  1  sole clock; all logic on its rising edge.
REQ-006 wrRst  in  1  reset, asynchronous, active-high.
REQ-007 wrPtr  in  N  write pointer from the write unit (lap bit + index).
REQ-008 wrPtrXfer  out  N  registered copy of wrPtr sent to the read domain; held stable while a transfer is in flight.
REQ-009 wrReq  out  1  toggles once per new wrPtrXfer value.
REQ-010 wrAckAsync  in  1  read-domain ack toggle for wrReq; asynchronous.
REQ-011 rdPtrXfer  in  N  read pointer bundle from the read domain; stable while rdReqAsync != rdAck.
REQ-012 rdReqAsync  in  1  read-domain request toggle; asynchronous.
REQ-013 rdAck  out  1  ack toggle returned to the read domain.
REQ-014 rdPtrSync  out  N  captured read pointer; drives the write unit's rdPtr input.
REQ-015 fillLevel  out  N  words stored as seen from the write side; registered.
REQ-016 almostFull  out  1  registered; 1 when fillLevel >= depth-AF_MARGIN.

Function
REQ-017 The send FSM SHALL have two states, S_IDLE and S_WAIT_ACK.
REQ-018 In S_IDLE with wrPtr != wrPtrXfer, the block SHALL, on one edge:
- load wrPtr into wrPtrXfer;
- invert wrReq;
- enter S_WAIT_ACK.
REQ-019 In S_IDLE with wrPtr == wrPtrXfer, the block SHALL hold all send-side registers.
REQ-020 wrAckAsync SHALL pass through SYNC_STAGES flops; the last stage is ackSync.
REQ-021 In S_WAIT_ACK, the FSM SHALL return to S_IDLE on the edge where ackSync == wrReq; wrPtrXfer and wrReq SHALL not change in S_WAIT_ACK.
REQ-022 wrPtr changes during S_WAIT_ACK SHALL be ignored; the next transfer carries the latest wrPtr, and skipping intermediate values is permitted.
REQ-023 rdReqAsync SHALL pass through SYNC_STAGES flops; the last stage is reqSync.
REQ-024 On the edge where reqSync != rdAck, the block SHALL load rdPtrXfer into rdPtrSync and set rdAck to reqSync.
- Latency from a rdReqAsync toggle to updated rdPtrSync/rdAck: exactly SYNC_STAGES+1 edges.
- Exactly one capture per toggle.
REQ-025 rdPtrXfer SHALL be sampled only on a capture edge and SHALL never feed other logic directly.
REQ-026 fillLevel SHALL be registered from wrPtr and rdPtrSync, with 1-cycle latency:
- lap bits equal: wrIdx - rdIdx;
- lap bits differ: depth - rdIdx + wrIdx.
- Arithmetic SHALL be N bits with no overflow for legal pointers.
REQ-027 Full condition: laps differ and indices equal SHALL give fillLevel = depth.
REQ-028 Empty condition: pointers equal SHALL give fillLevel = 0.
REQ-029 Index wrap from depth-1 to 0 with lap toggle SHALL be handled by REQ-026; no power-of-two assumption.
REQ-030 The send and receive paths SHALL be independent; a simultaneous send start and receive capture on one edge SHALL both complete.

Reset
REQ-031 While wrRst = 1, the block SHALL asynchronously force:
- FSM to S_IDLE;
- wrPtrXfer, wrReq, rdAck, rdPtrSync, fillLevel, almostFull and all synchronizer flops to 0.
REQ-032 Reset mid-handshake SHALL abandon the transfer; the read domain is reset concurrently at system level.
REQ-033 After reset release with wrPtr = 0, no transfer SHALL start.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Reset then release with wrPtr = 0 -> all outputs 0, FSM S_IDLE, wrReq stays 0.
- wrPtr 0->5 -> next edge wrPtrXfer = 5, wrReq = 1. Then wrPtr = 9 with wrAckAsync held 0 -> wrPtrXfer stays 5. Then wrAckAsync = 1 -> S_IDLE after 2 edges, following edge wrPtrXfer = 9, wrReq = 0.
- rdPtrXfer = 0x0003, toggle rdReqAsync 0->1 -> rdPtrSync = 3 and rdAck = 1 exactly 3 edges later; no further change without a new toggle.
- Wrap: wrPtr = 0x8002, rdPtrSync = 0x67FE -> fillLevel = 4 one edge later.
- Full/empty: wrPtr = 0x8100, rdPtrSync = 0x0100 -> fillLevel = 0x6800, almostFull = 1. Then wrPtr = 0x0100 -> fillLevel = 0, almostFull = 0.
- Threshold and reset: fillLevel 0x67FB -> almostFull = 0; 0x67FC -> 1. Assert wrRst in S_WAIT_ACK -> immediate S_IDLE, wrReq = 0.
